// File: rtl/piksel_paketleyici.sv
// Packs the 8-bit pixel stream into 32-bit little-endian words, buffers them in a
// small FWFT FIFO and presents them with a frame-relative word address.
module piksel_paketleyici #(
    parameter int IMG_W         = 320,
    parameter int IMG_H         = 240,
    parameter int FIFO_DERINLIK = 8,
    parameter int ADRES_W       = 15
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               basla_i,
    input  logic               etkin_i,
    input  logic [7:0]         pixel_i,
    output logic [31:0]        veri_o,
    output logic               gecerli_o,
    input  logic               hazir_i,
    output logic [ADRES_W-1:0] adres_o,
    output logic               cerceve_bitti_o,
    output logic               tasma_o,
    output logic               mesgul_o
);
    localparam int TOPLAM = IMG_W * IMG_H;
    localparam int PW     = $clog2(TOPLAM + 1);
    localparam int FW     = $clog2(FIFO_DERINLIK);
    localparam int CW     = $clog2(FIFO_DERINLIK + 1);

    typedef enum logic [1:0] {BOSTA, TOPLA, BOSALT} durum_t;

    durum_t        durum;
    logic [PW-1:0] pix_say;
    logic [23:0]   paket;
    logic [31:0]   mem [FIFO_DERINLIK];
    logic [FW-1:0] yaz_ptr, oku_ptr;
    logic [CW-1:0] doluluk;
    logic          dolu, pop, push_iste, push, son_piksel;

    assign gecerli_o  = (doluluk != '0);
    assign dolu       = (doluluk == CW'(FIFO_DERINLIK));
    assign pop        = gecerli_o && hazir_i;
    assign push_iste  = (durum == TOPLA) && etkin_i && (pix_say[1:0] == 2'd3);
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push       = push_iste && (!dolu || pop);
    assign son_piksel = (pix_say == PW'(TOPLAM - 1));
    assign veri_o     = gecerli_o ? mem[oku_ptr] : 32'd0;
    assign mesgul_o   = (durum != BOSTA);

    always_ff @(posedge clk_i) begin
        if (rstn_i && !basla_i && push)
            mem[yaz_ptr] <= {pixel_i, paket};
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            durum           <= BOSTA;
            pix_say         <= '0;
            paket           <= '0;
            yaz_ptr         <= '0;
            oku_ptr         <= '0;
            doluluk         <= '0;
            adres_o         <= '0;
            cerceve_bitti_o <= 1'b0;
            tasma_o         <= 1'b0;
        end else if (basla_i) begin
            durum           <= TOPLA;
            pix_say         <= '0;
            paket           <= '0;
            yaz_ptr         <= '0;
            oku_ptr         <= '0;
            doluluk         <= '0;
            adres_o         <= '0;
            cerceve_bitti_o <= 1'b0;
            tasma_o         <= 1'b0;
        end else begin
            cerceve_bitti_o <= 1'b0;
            if (push) yaz_ptr <= yaz_ptr + FW'(1);
            if (pop) begin
                oku_ptr <= oku_ptr + FW'(1);
                adres_o <= adres_o + ADRES_W'(1);
            end
            case ({push, pop})
                2'b10:   doluluk <= doluluk + CW'(1);
                2'b01:   doluluk <= doluluk - CW'(1);
                default: doluluk <= doluluk;
            endcase
            if (push_iste && dolu && !pop) tasma_o <= 1'b1;

            case (durum)
                TOPLA: begin
                    if (etkin_i) begin
                        case (pix_say[1:0])
                            2'd0:    paket[7:0]   <= pixel_i;
                            2'd1:    paket[15:8]  <= pixel_i;
                            2'd2:    paket[23:16] <= pixel_i;
                            default: paket        <= paket;
                        endcase
                        pix_say <= pix_say + PW'(1);
                        if (son_piksel) durum <= BOSALT;
                    end
                end
                BOSALT: begin
                    // No pushes happen here, so the FIFO is never empty on entry.
                    if (pop && doluluk == CW'(1)) begin
                        durum           <= BOSTA;
                        cerceve_bitti_o <= 1'b1;
                    end
                end
                default: durum <= BOSTA;
            endcase
        end
    end
endmodule

// File: tb/tb_piksel_paketleyici.sv
// Directed bench for piksel_paketleyici on a reduced 32x8 frame (64 words).
module tb_piksel_paketleyici;
    localparam int NW = 64;

    logic        clk = 1'b0;
    logic        rstn = 1'b0, basla = 1'b0, etkin = 1'b0, hazir = 1'b0;
    logic [7:0]  pixel = 8'd0;
    logic [31:0] veri;
    logic        gecerli, bitti, tasma, mesgul;
    logic [7:0]  adres;

    logic [31:0] q_veri[$];
    logic [7:0]  q_adr[$];
    int          n_done, n_vec, n_bad;

    piksel_paketleyici #(.IMG_W(32), .IMG_H(8), .FIFO_DERINLIK(8), .ADRES_W(8)) dut (
        .clk_i(clk), .rstn_i(rstn), .basla_i(basla), .etkin_i(etkin), .pixel_i(pixel),
        .veri_o(veri), .gecerli_o(gecerli), .hazir_i(hazir), .adres_o(adres),
        .cerceve_bitti_o(bitti), .tasma_o(tasma), .mesgul_o(mesgul));

    always #5 clk = ~clk;

    function automatic logic [7:0] pv(input int i, input int k, input int c);
        int t;
        t = i * k + c;
        return t[7:0];
    endfunction

    function automatic logic [31:0] gw(input int w, input int k, input int c);
        return {pv(4*w+3, k, c), pv(4*w+2, k, c), pv(4*w+1, k, c), pv(4*w, k, c)};
    endfunction

    // At each negedge: record any transfer the coming edge will make, then drive inputs.
    task automatic cyc(input logic b, input logic e, input logic [7:0] p, input logic h);
        @(negedge clk);
        if (gecerli && h) begin
            q_veri.push_back(veri);
            q_adr.push_back(adres);
        end
        if (bitti) n_done++;
        basla = b; etkin = e; pixel = p; hazir = h;
    endtask

    task automatic clr();
        q_veri.delete(); q_adr.delete(); n_done = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cyc(0, 1, 8'h55, 1);
        cyc(0, 1, 8'h56, 1);
        n_vec++; if (veri !== 32'd0) begin n_bad++; $display("FAIL reset_veri got %h want 0", veri); end
        n_vec++; if (gecerli !== 1'b0) begin n_bad++; $display("FAIL reset_gecerli got %b want 0", gecerli); end
        n_vec++; if (adres !== 8'd0) begin n_bad++; $display("FAIL reset_adres got %0d want 0", adres); end
        n_vec++; if (bitti !== 1'b0) begin n_bad++; $display("FAIL reset_bitti got %b want 0", bitti); end
        n_vec++; if (tasma !== 1'b0) begin n_bad++; $display("FAIL reset_tasma got %b want 0", tasma); end
        n_vec++; if (mesgul !== 1'b0) begin n_bad++; $display("FAIL reset_mesgul got %b want 0", mesgul); end
        rstn = 1'b1;
        clr();
        for (int i = 0; i < 12; i++) cyc(0, 1, 8'(i), 1);
        n_vec++; if (gecerli !== 1'b0 || q_veri.size() != 0) begin
            n_bad++; $display("FAIL idle_etkin gecerli %b words %0d want 0/0", gecerli, q_veri.size()); end
        n_vec++; if (mesgul !== 1'b0) begin n_bad++; $display("FAIL idle_mesgul got %b want 0", mesgul); end
    endtask

    task automatic test_full_frame();
        clr();
        cyc(1, 0, 8'd0, 1);
        for (int i = 0; i < 256; i++) cyc(0, 1, pv(i, 1, 0), 1);
        for (int i = 0; i < 20; i++) cyc(0, 0, 8'd0, 1);
        n_vec++; if (q_veri.size() != NW) begin
            n_bad++; $display("FAIL full_count got %0d want %0d", q_veri.size(), NW); end
        if (q_veri.size() == NW) begin
            n_vec++; if (q_veri[0] !== 32'h03020100 || q_adr[0] !== 8'd0) begin
                n_bad++; $display("FAIL full_first got %h@%0d want 03020100@0", q_veri[0], q_adr[0]); end
            n_vec++; if (q_veri[63] !== 32'hFFFEFDFC || q_adr[63] !== 8'd63) begin
                n_bad++; $display("FAIL full_last got %h@%0d want fffefdfc@63", q_veri[63], q_adr[63]); end
            for (int i = 0; i < NW; i++) begin
                n_vec++; if (q_veri[i] !== gw(i, 1, 0) || q_adr[i] !== 8'(i)) begin
                    n_bad++; $display("FAIL full_word%0d got %h@%0d want %h@%0d", i, q_veri[i], q_adr[i], gw(i, 1, 0), i); end
            end
        end
        n_vec++; if (n_done != 1) begin n_bad++; $display("FAIL full_done got %0d pulses want 1", n_done); end
        n_vec++; if (tasma !== 1'b0) begin n_bad++; $display("FAIL full_tasma got %b want 0", tasma); end
        n_vec++; if (mesgul !== 1'b0 || gecerli !== 1'b0) begin
            n_bad++; $display("FAIL full_end mesgul %b gecerli %b want 0/0", mesgul, gecerli); end
    endtask

    task automatic test_latency();
        clr();
        cyc(1, 0, 8'd0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 8'(i), 0);
        n_vec++; if (gecerli !== 1'b0) begin n_bad++; $display("FAIL lat_before got %b want 0", gecerli); end
        @(posedge clk); #1;
        n_vec++; if (gecerli !== 1'b1 || veri !== 32'h03020100 || adres !== 8'd0) begin
            n_bad++; $display("FAIL lat_after got %b %h@%0d want 1 03020100@0", gecerli, veri, adres); end
    endtask

    task automatic test_overflow();
        clr();
        cyc(1, 0, 8'd0, 0);
        for (int i = 0; i < 256; i++) begin
            cyc(0, 1, pv(i, 1, 0), (i >= 160));
            if (i == 35) begin
                n_vec++; if (tasma !== 1'b0) begin n_bad++; $display("FAIL ovf_8th got %b want 0", tasma); end
            end
            if (i == 36) begin
                n_vec++; if (tasma !== 1'b1) begin n_bad++; $display("FAIL ovf_9th got %b want 1", tasma); end
            end
        end
        for (int i = 0; i < 20; i++) cyc(0, 0, 8'd0, 1);
        n_vec++; if (q_veri.size() != 32) begin
            n_bad++; $display("FAIL ovf_count got %0d want 32", q_veri.size()); end
        if (q_veri.size() == 32) begin
            for (int i = 0; i < 32; i++) begin
                n_vec++; if (q_veri[i] !== gw((i < 8) ? i : i + 32, 1, 0) || q_adr[i] !== 8'(i)) begin
                    n_bad++; $display("FAIL ovf_word%0d got %h@%0d want %h@%0d", i, q_veri[i], q_adr[i],
                                      gw((i < 8) ? i : i + 32, 1, 0), i); end
            end
        end
        n_vec++; if (tasma !== 1'b1 || n_done != 1) begin
            n_bad++; $display("FAIL ovf_end tasma %b done %0d want 1/1", tasma, n_done); end
    endtask

    task automatic test_random();
        logic rh;
        clr();
        cyc(1, 0, 8'd0, 0);
        for (int i = 0; i < 256; i++) begin
            int g;
            g = $urandom_range(1, 3);
            for (int j = 0; j < g; j++) begin
                rh = ($urandom_range(0, 3) != 0);
                cyc(0, 0, 8'd0, rh);
            end
            rh = ($urandom_range(0, 3) != 0);
            cyc(0, 1, pv(i, 5, 1), rh);
        end
        for (int i = 0; i < 80; i++) begin
            rh = ($urandom_range(0, 3) != 0);
            cyc(0, 0, 8'd0, rh);
        end
        n_vec++; if (q_veri.size() != NW) begin
            n_bad++; $display("FAIL rnd_count got %0d want %0d", q_veri.size(), NW); end
        if (q_veri.size() == NW) begin
            for (int i = 0; i < NW; i++) begin
                n_vec++; if (q_veri[i] !== gw(i, 5, 1) || q_adr[i] !== 8'(i)) begin
                    n_bad++; $display("FAIL rnd_word%0d got %h@%0d want %h@%0d", i, q_veri[i], q_adr[i], gw(i, 5, 1), i); end
            end
        end
        n_vec++; if (tasma !== 1'b0 || n_done != 1) begin
            n_bad++; $display("FAIL rnd_end tasma %b done %0d want 0/1", tasma, n_done); end
    endtask

    task automatic test_restart();
        clr();
        cyc(1, 0, 8'd0, 0);
        for (int i = 0; i < 100; i++) cyc(0, 1, pv(i, 1, 0), 0);
        n_vec++; if (tasma !== 1'b1 || gecerli !== 1'b1) begin
            n_bad++; $display("FAIL rst_pre tasma %b gecerli %b want 1/1", tasma, gecerli); end
        cyc(1, 1, 8'hAA, 0);
        cyc(0, 0, 8'd0, 1);
        n_vec++; if (gecerli !== 1'b0 || tasma !== 1'b0 || adres !== 8'd0 || mesgul !== 1'b1) begin
            n_bad++; $display("FAIL rst_flush gecerli %b tasma %b adres %0d mesgul %b want 0/0/0/1",
                              gecerli, tasma, adres, mesgul); end
        clr();
        for (int i = 0; i < 256; i++) cyc(0, 1, pv(i, 3, 5), 1);
        for (int i = 0; i < 20; i++) cyc(0, 0, 8'd0, 1);
        n_vec++; if (q_veri.size() != NW) begin
            n_bad++; $display("FAIL rst_count got %0d want %0d", q_veri.size(), NW); end
        if (q_veri.size() > 0) begin
            n_vec++; if (q_veri[0] !== 32'h0E0B0805 || q_adr[0] !== 8'd0) begin
                n_bad++; $display("FAIL rst_first got %h@%0d want 0e0b0805@0", q_veri[0], q_adr[0]); end
        end
        n_vec++; if (n_done != 1) begin n_bad++; $display("FAIL rst_done got %0d want 1", n_done); end
    endtask

    task automatic test_midreset();
        clr();
        cyc(1, 0, 8'd0, 0);
        for (int i = 0; i < 50; i++) cyc(0, 1, pv(i, 1, 0), 0);
        rstn = 1'b0;
        cyc(0, 1, 8'h77, 1);
        n_vec++; if (veri !== 32'd0 || gecerli !== 1'b0 || adres !== 8'd0 || bitti !== 1'b0 ||
                     tasma !== 1'b0 || mesgul !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset veri %h gecerli %b adres %0d bitti %b tasma %b mesgul %b want all 0",
                              veri, gecerli, adres, bitti, tasma, mesgul); end
        rstn = 1'b1;
        clr();
        for (int i = 0; i < 24; i++) cyc(0, 1, 8'(i), 1);
        n_vec++; if (gecerli !== 1'b0 || mesgul !== 1'b0 || q_veri.size() != 0) begin
            n_bad++; $display("FAIL mid_ignore gecerli %b mesgul %b words %0d want 0/0/0",
                              gecerli, mesgul, q_veri.size()); end
    endtask

    initial begin
        n_vec = 0; n_bad = 0; n_done = 0;
        test_reset();
        test_full_frame();
        test_latency();
        test_overflow();
        test_random();
        test_restart();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
